// File: rtl/mul_booth_seq_if.sv
// Operand/result bundle for the sequential radix-4 Booth multiplier.
//
// Handshake: the requester drives start high together with x, y and
// is_signed. The request is taken on a rising clock edge where busy is
// low. While busy is high, start and the operands are ignored. When busy
// is low again, done pulses high for exactly one cycle and rslt becomes
// valid. rslt then stays stable until the next request is taken.
interface mul_booth_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     rslt;

    modport master (
        output start, is_signed, x, y,
        input  busy, done, rslt
    );

    modport slave (
        input  start, is_signed, x, y,
        output busy, done, rslt
    );
endinterface

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier. It retires one Booth digit (two
// multiplier bits) per clock. Both operands are extended by two bits at
// load, which makes signed and unsigned products exact. The cost is one
// extra digit: N = WIDTH/2 + 1 digits, with a fixed latency of N + 1 cycles.
module mul_booth_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH/2+2)
) (
    input  logic            clk,
    input  logic            clr,
    mul_booth_seq_if.slave  bus,
    output logic [1:0]      dbg_state_o
);
    localparam int EW = WIDTH + 2;      // extended operand width
    localparam int PW = WIDTH + 3;      // partial product, holds +/-2X
    localparam int AW = 2*EW + 1;       // {upper, multiplier, booth bit}
    localparam logic [CNT_W-1:0] N_DIG = CNT_W'(WIDTH/2 + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [AW-1:0]          acc_q;
    logic [EW-1:0]          xe_q;
    logic                   busy_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     rslt_q;

    logic [EW-1:0]          xe_load_d;
    logic [AW-1:0]          acc_load_d;
    logic [EW-1:0]          upper;
    logic [PW-1:0]          px;
    logic [PW-1:0]          p2x;
    logic [PW-1:0]          pp;
    logic [EW+1:0]          sum_d;
    logic [AW-1:0]          acc_step_d;

    // Operand extension and the initial accumulator: upper half clear, the
    // multiplier in the middle, and the appended Booth bit y[-1] = 0.
    always_comb begin
        xe_load_d  = bus.is_signed ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
        acc_load_d = {{EW{1'b0}},
                      (bus.is_signed ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y}),
                      1'b0};
    end

    // Recode the low 3-bit window into a digit and fold it into the upper
    // half. The sum is two bits wider than the upper half, so dropping the
    // two bits that shift out keeps the value exact (arithmetic shift by 2).
    always_comb begin
        upper = acc_q[AW-1:EW+1];
        px    = {xe_q[EW-1], xe_q};
        p2x   = {xe_q, 1'b0};
        pp    = '0;
        case (acc_q[2:0])
            3'b001, 3'b010: pp = px;
            3'b011:         pp = p2x;
            3'b100:         pp = -p2x;
            3'b101, 3'b110: pp = -px;
            default:        pp = '0;
        endcase
        sum_d      = {{2{upper[EW-1]}}, upper} + {pp[PW-1], pp};
        acc_step_d = {sum_d, acc_q[EW:2]};
    end

    // Control FSM with registered busy/done/rslt outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            xe_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rslt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        xe_q    <= xe_load_d;
                        acc_q   <= acc_load_d;
                        cnt_q   <= N_DIG;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_step_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    rslt_q <= acc_q[2*WIDTH:1];
                    if (bus.start) begin
                        xe_q    <= xe_load_d;
                        acc_q   <= acc_load_d;
                        cnt_q   <= N_DIG;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rslt    = rslt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Directed bench for mul_booth_seq at WIDTH=32: reset, signed and unsigned
// corner products, fixed latency, start-while-busy, back-to-back operation.
module tb_mul_booth_seq;
    logic        clk;
    logic        clr;
    logic [1:0]  dbg_state;
    int          n_checks;
    int          n_fail;

    mul_booth_seq_if #(.WIDTH(32)) bus ();

    mul_booth_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present one request, then wait (bounded) for done.
    // lat counts rising edges after the accepting edge; 100 means timeout.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] p, output int lat);
        @(negedge clk);
        bus.x = a;
        bus.y = b;
        bus.is_signed = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        p = '0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                p = bus.rslt;
                break;
            end
        end
    endtask

    task automatic test_reset_state();
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rslt !== 64'h0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b rslt=%h state=%0d, need 0 0 0 0",
                     bus.busy, bus.done, bus.rslt, dbg_state);
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_signed();
        logic [31:0] ax [5];
        logic [31:0] bx [5];
        logic [63:0] ex [5];
        logic [63:0] p;
        int lat;
        ax = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        bx = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        ex = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000,
               64'hC000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            do_mul(ax[i], bx[i], 1'b1, p, lat);
            n_checks++;
            if (p !== ex[i]) begin
                n_fail++;
                $display("FAIL signed_prod[%0d]: %h*%h got %h need %h", i, ax[i], bx[i], p, ex[i]);
            end
            n_checks++;
            if (lat != 18) begin
                n_fail++;
                $display("FAIL signed_latency[%0d]: got %0d need 18", i, lat);
            end
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] ax [5];
        logic [31:0] bx [5];
        logic [63:0] ex [5];
        logic [63:0] p;
        int lat;
        ax = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0010};
        bx = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0020};
        ex = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0001_0000_0000, 64'h0,
               64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0200};
        for (int i = 0; i < 5; i++) begin
            do_mul(ax[i], bx[i], 1'b0, p, lat);
            n_checks++;
            if (p !== ex[i]) begin
                n_fail++;
                $display("FAIL unsigned_prod[%0d]: %h*%h got %h need %h", i, ax[i], bx[i], p, ex[i]);
            end
            n_checks++;
            if (lat != 18) begin
                n_fail++;
                $display("FAIL unsigned_latency[%0d]: got %0d need 18", i, lat);
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [63:0] p;
        int lat;
        int done_cnt;
        @(negedge clk);
        bus.x = 32'd5;
        bus.y = 32'd7;
        bus.is_signed = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rslt !== 64'h0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_calc: busy=%b done=%b rslt=%h state=%0d, need 0 0 0 0",
                     bus.busy, bus.done, bus.rslt, dbg_state);
        end
        repeat (3) @(negedge clk);
        clr = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d busy/done cycles need 0", done_cnt);
        end
        do_mul(32'd2, 32'd3, 1'b0, p, lat);
        n_checks++;
        if (p !== 64'd6 || lat != 18) begin
            n_fail++;
            $display("FAIL reset_fresh_op: got %h lat %0d need 6 lat 18", p, lat);
        end
    endtask

    task automatic test_start_while_busy();
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [63:0] p;
        @(negedge clk);
        bus.x = 32'd3;
        bus.y = 32'd5;
        bus.is_signed = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        p = '0;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = i;
                p = bus.rslt;
            end
            if (i < 10) begin
                bus.x = 32'hFFFF_0000 ^ i;
                bus.y = 32'h8000_0001 + i;
                bus.is_signed = ~bus.is_signed;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
        end
        n_checks++;
        if (busy_cnt != 17) begin
            n_fail++;
            $display("FAIL busy_cycles: got %0d need 17", busy_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != 18) begin
            n_fail++;
            $display("FAIL single_done: got %0d pulses at %0d need 1 at 18", done_cnt, done_at);
        end
        n_checks++;
        if (p !== 64'd15) begin
            n_fail++;
            $display("FAIL first_op_prod: got %h need %h", p, 64'd15);
        end
        #1;
        n_checks++;
        if (bus.rslt !== 64'd15 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rslt_hold_idle: got %h busy=%b need %h busy=0", bus.rslt, bus.busy, 64'd15);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int changes;
        @(negedge clk);
        bus.x = 32'hFFFF_FFF9;
        bus.y = 32'h0000_0003;
        bus.is_signed = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        n_checks++;
        if (dbg_state !== 2'd2 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_state: state=%0d busy=%b done=%b need 2 0 0", dbg_state, bus.busy, bus.done);
        end
        bus.x = 32'hFFFF_FFFF;
        bus.y = 32'hFFFF_FFFF;
        bus.is_signed = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.rslt !== 64'hFFFF_FFFF_FFFF_FFEB || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b busy=%b rslt=%h need 1 1 %h",
                     bus.done, bus.busy, bus.rslt, 64'hFFFF_FFFF_FFFF_FFEB);
        end
        lat = 0;
        changes = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
            if (bus.rslt !== 64'hFFFF_FFFF_FFFF_FFEB) changes++;
        end
        n_checks++;
        if (lat != 18) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d need 18", lat);
        end
        n_checks++;
        if (changes != 0) begin
            n_fail++;
            $display("FAIL rslt_stable_calc: got %0d changes need 0", changes);
        end
        n_checks++;
        if (bus.rslt !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("FAIL b2b_second: got %h need %h", bus.rslt, 64'hFFFF_FFFE_0000_0001);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        clr = 1'b0;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.x = '0;
        bus.y = '0;
        test_reset_state();
        test_signed();
        test_unsigned();
        test_reset_mid_calc();
        test_start_while_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_booth_seq.md
Name: mul_booth_seq

Overview:
Iterative radix-4 Booth multiplier: a parametrised, multi-cycle successor to the CPU's combinational 32x32 multiplier. It retires one Booth digit (two multiplier bits) per clock. It supports signed and unsigned operands via a mode input, and it uses a start/busy/done handshake. It sits beside the ALU and feeds HI/LO with the 2*WIDTH-bit product, trading latency for area.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4
CNT_W, $clog2(WIDTH/2+2), iteration counter width (derived, do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
clr  input  1  reset, asynchronous, active-low; clears all state when 0
start  input  1  request a multiply; sampled only when not busy
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
x  input  WIDTH  multiplicand, sampled with start
y  input  WIDTH  multiplier, sampled with start
busy  output  1  high while an operation is in progress (CALC state)
done  output  1  one-cycle pulse, product valid
rslt  output  2*WIDTH  product; held stable from done until the next accepted start

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, busy=0, done=0, rslt=0, counter=0, internal accumulator/operand registers=0. Reset mid-operation aborts it; no done pulse follows.
- Operand extension at load:
  - x and y are extended to WIDTH+2 bits: sign-extended if is_signed=1, zero-extended otherwise.
  - This makes the unsigned case exact, at the cost of one extra digit.
  - Number of digits N = WIDTH/2 + 1 (17 for WIDTH=32).
- States:
  - IDLE: busy=0. On start=1, load the extended operands, clear the accumulator, set the appended Booth bit y[-1]=0, set counter=N, and go to CALC.
  - CALC: busy=1. Each cycle, recode the 3-bit window {y[i+1], y[i], y[i-1]} to a digit:
    - 000, 111 -> 0
    - 001, 010 -> +X
    - 011 -> +2X
    - 100 -> -2X
    - 101, 110 -> -X
    - The digit is added, with correct sign extension, into the upper part of the accumulator. The accumulator then shifts arithmetically right by 2. Decrement the counter. When the counter reaches 1 on this cycle's digit, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, and rslt is loaded with the low 2*WIDTH bits of the final accumulator. Next state is IDLE. If start=1 during DONE, the new operation is accepted: load as in IDLE and go directly to CALC, with done still pulsing this cycle.
- Latency: start sampled at edge k -> done high after edge k+N+1 (18 cycles for WIDTH=32). Fixed and data-independent.
- start while busy=1 is ignored; operands and mode may change freely during CALC without effect.
- rslt does not change during CALC; it updates only on entry to DONE. It holds its value indefinitely in IDLE.
- Arithmetic:
  - The partial-product datapath is WIDTH+3 bits, sufficient for ±2X of the extended operand.
  - The accumulator is 2*(WIDTH+2)+1 bits, including the Booth bit.
  - No overflow is possible; the result equals the exact mathematical product modulo 2^(2*WIDTH). This covers both the signed (-2^(W-1))^2 case and the unsigned (2^W-1)^2 case.

Test Plan:
- Reset: hold clr=0 for 3 cycles mid-CALC, release -> busy=0, done=0, rslt=0; no done pulse until a fresh start.
- Signed corners (WIDTH=32):
  - -7*3 -> rslt=0xFFFFFFFF_FFFFFFEB.
  - -1*-1 -> 0x00000000_00000001.
  - 0x80000000*0x80000000 -> 0x40000000_00000000.
  - done exactly 18 cycles after the start edge.
- Unsigned corners:
  - 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001.
  - 0x80000000*2 -> 0x00000001_00000000.
  - 0*0xDEADBEEF -> 0.
- Handshake:
  - start held high and operands toggled during CALC -> only the first operation's product appears; busy stays high for 17 cycles.
  - Back-to-back start asserted in the DONE cycle -> second done exactly 18 cycles later with the correct second product.
- Parameter sweep:
  - WIDTH=8: exhaustive 65536 pairs in both modes against a $signed/$unsigned reference model; done latency 6 cycles.
  - WIDTH=4: exhaustive in both modes.
- Random: 10k random operand/mode pairs at WIDTH=32 vs reference model; rslt stable between done and the next start.
